// File: rtl/udp_tx_arbiter.sv
// Two-channel round-robin front end for a single UDP transmit engine.
// Validates lengths, runs one packet at a time, inserts an inter-packet gap and times out a hung engine.
module udp_tx_arbiter #(
  parameter logic [15:0] MAX_BYTES  = 16'd1472,
  parameter logic [7:0]  IFG_CYCLES = 8'd12,
  parameter logic [15:0] TIMEOUT    = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_byte_num,
  input  logic [31:0] req0_data,
  output logic        req0_grant,
  output logic        req0_rd,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [15:0] req1_byte_num,
  input  logic [31:0] req1_data,
  output logic        req1_grant,
  output logic        req1_rd,
  output logic        req1_done,
  output logic        req1_err,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy,
  output logic        tx_timeout
);

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_START = 4'b0010;
  localparam logic [3:0] S_WAIT  = 4'b0100;
  localparam logic [3:0] S_GAP   = 4'b1000;

  logic [3:0]  state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [15:0] byte_num_q, byte_num_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        timeout_q, timeout_d;

  logic        pick;
  logic [15:0] pick_len;
  logic        len_ok;

  // Contention goes to the channel that was not served last.
  assign pick     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign pick_len = pick ? req1_byte_num : req0_byte_num;
  assign len_ok   = (pick_len != 16'd0) && (pick_len <= MAX_BYTES);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    byte_num_d = byte_num_q;
    cnt_d      = cnt_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          last_d = pick;
          cnt_d  = 16'd0;
          if (len_ok) begin
            sel_d      = pick;
            byte_num_d = pick_len;
            state_d    = S_START;
          end else begin
            err_d[pick] = 1'b1;
            state_d     = S_GAP;
          end
        end
      end
      S_START: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the last timeout cycle still counts as success.
        if (tx_done) begin
          done_d[sel_q] = 1'b1;
          cnt_d         = 16'd0;
          state_d       = S_GAP;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          timeout_d = 1'b1;
          cnt_d     = 16'd0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == {8'd0, IFG_CYCLES} - 16'd1) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      byte_num_q <= 16'd0;
      cnt_q      <= 16'd0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      byte_num_q <= byte_num_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_start_en = (state_q == S_START);
  assign req0_grant  = (state_q == S_START) && !sel_q;
  assign req1_grant  = (state_q == S_START) &&  sel_q;
  assign req0_rd     = (state_q == S_WAIT) && tx_req && !sel_q;
  assign req1_rd     = (state_q == S_WAIT) && tx_req &&  sel_q;
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign req0_err    = err_q[0];
  assign req1_err    = err_q[1];
  assign tx_timeout  = timeout_q;
  assign tx_byte_num = byte_num_q;
  assign tx_data     = sel_q ? req1_data : req0_data;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: directed and randomized transactions
// compared against a small arbitration/timing model kept in the bench.
module tb_udp_tx_arbiter;

   localparam int MAXB = 1472;
   localparam int IFG  = 12;
   localparam int TMO  = 100;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [15:0] req0_byte_num, req1_byte_num;
   logic [31:0] req0_data, req1_data;
   logic        req0_grant, req0_rd, req0_done, req0_err;
   logic        req1_grant, req1_rd, req1_done, req1_err;
   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic [31:0] tx_data;
   logic        tx_req, tx_done;
   logic        busy, tx_timeout;

   int checks   = 0;
   int failures = 0;

   // Model state: channel served last, and length the engine should be holding.
   bit          rrLast;
   logic [15:0] heldLen;

   udp_tx_arbiter #(
      .MAX_BYTES(16'd1472),
      .IFG_CYCLES(8'd12),
      .TIMEOUT(16'd100)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_byte_num(req0_byte_num), .req0_data(req0_data),
      .req0_grant(req0_grant), .req0_rd(req0_rd), .req0_done(req0_done), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_byte_num(req1_byte_num), .req1_data(req1_data),
      .req1_grant(req1_grant), .req1_rd(req1_rd), .req1_done(req1_done), .req1_err(req1_err),
      .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_data(tx_data),
      .tx_req(tx_req), .tx_done(tx_done), .busy(busy), .tx_timeout(tx_timeout)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every step happens 1 ns after the rising edge so registered outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] randLen();
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0)
         return ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(MAXB + 1, 65535));
      return 16'($urandom_range(1, MAXB));
   endfunction

   // The gap is IFG cycles long; engine strobes seen there must be ignored.
   task automatic checkGap(input string tag);
      tx_req  = 1'b1;
      tx_done = 1'b1;
      #1;
      checkBit({tag, "_gap_rd0"}, req0_rd, 1'b0);
      checkBit({tag, "_gap_rd1"}, req1_rd, 1'b0);
      tick();
      tx_req  = 1'b0;
      tx_done = 1'b0;
      checkBit({tag, "_gap_done0"}, req0_done, 1'b0);
      checkBit({tag, "_gap_done1"}, req1_done, 1'b0);
      repeat (IFG - 2) tick();
      checkBit({tag, "_gap_busy"}, busy, 1'b1);
      checkWord({tag, "_gap_bytenum"}, {16'd0, tx_byte_num}, {16'd0, heldLen});
      tick();
      checkBit({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   // One request from IDLE through grant/reject, payload beats, done and gap.
   task automatic applyStimulus(input string tag, input bit v0, input bit v1,
                                input logic [15:0] l0, input logic [15:0] l1, input int beats);
      bit          k;
      logic [15:0] len;
      bit          ok;
      req0_valid    = v0;
      req1_valid    = v1;
      req0_byte_num = l0;
      req1_byte_num = l1;
      k   = (v0 && v1) ? ~rrLast : v1;
      len = k ? l1 : l0;
      ok  = (len != 16'd0) && (int'(len) <= MAXB);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rrLast     = k;
      if (ok) begin
         heldLen = len;
         checkBit({tag, "_start"}, tx_start_en, 1'b1);
         checkBit({tag, "_grant0"}, req0_grant, !k);
         checkBit({tag, "_grant1"}, req1_grant, k);
         checkBit({tag, "_err"}, req0_err | req1_err, 1'b0);
         checkWord({tag, "_bytenum"}, {16'd0, tx_byte_num}, {16'd0, len});
         tick();
         checkBit({tag, "_wait_start"}, tx_start_en, 1'b0);
         for (int b = 0; b < beats; b++) begin
            req0_data = $urandom;
            req1_data = $urandom;
            tx_req    = 1'b1;
            #1;
            checkBit({tag, "_rd0"}, req0_rd, !k);
            checkBit({tag, "_rd1"}, req1_rd, k);
            checkWord({tag, "_txdata"}, tx_data, k ? req1_data : req0_data);
            tick();
            tx_req = 1'b0;
         end
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         checkBit({tag, "_done0"}, req0_done, !k);
         checkBit({tag, "_done1"}, req1_done, k);
         checkBit({tag, "_no_timeout"}, tx_timeout, 1'b0);
      end else begin
         checkBit({tag, "_rej_err0"}, req0_err, !k);
         checkBit({tag, "_rej_err1"}, req1_err, k);
         checkBit({tag, "_rej_start"}, tx_start_en, 1'b0);
         checkBit({tag, "_rej_grant"}, req0_grant | req1_grant, 1'b0);
         checkBit({tag, "_rej_busy"}, busy, 1'b1);
      end
      checkGap(tag);
   endtask

   // Grant ch0 alone and let the engine stay silent; optionally finish on the last allowed cycle.
   task checkOutput(input string tag, input bit lateDone);
      req0_valid    = 1'b1;
      req1_valid    = 1'b0;
      req0_byte_num = 16'd100;
      tick();
      req0_valid = 1'b0;
      rrLast     = 1'b0;
      heldLen    = 16'd100;
      checkBit({tag, "_grant0"}, req0_grant, 1'b1);
      tick();
      repeat (TMO - 1) tick();
      checkBit({tag, "_early"}, tx_timeout, 1'b0);
      checkBit({tag, "_busy"}, busy, 1'b1);
      tx_done = lateDone;
      tick();
      tx_done = 1'b0;
      checkBit({tag, "_timeout"}, tx_timeout, !lateDone);
      checkBit({tag, "_done0"}, req0_done, lateDone);
      checkGap(tag);
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_byte_num = 16'd0; req1_byte_num = 16'd0;
      req0_data = $urandom; req1_data = $urandom;
      tx_req = 1'b0; tx_done = 1'b0;
      rrLast = 1'b1;
      heldLen = 16'd0;
      tick();
      tick();
      checkBit("reset_busy", busy, 1'b0);
      checkBit("reset_start", tx_start_en, 1'b0);
      checkWord("reset_bytenum", {16'd0, tx_byte_num}, 32'd0);
      checkWord("reset_txdata", tx_data, req0_data);
      checkBit("reset_pulses", req0_grant | req1_grant | req0_done | req1_done |
               req0_err | req1_err | tx_timeout, 1'b0);
      rst = 1'b0;
      tick();

      $display("[TB] single request");
      applyStimulus("single", 1'b1, 1'b0, 16'd16, 16'd0, 4);

      $display("[TB] round robin");
      for (int i = 0; i < 4; i++)
         applyStimulus("rr", 1'b1, 1'b1, 16'd8, 16'd8, 2);

      $display("[TB] length reject");
      applyStimulus("rej_zero", 1'b0, 1'b1, 16'd0, 16'd0, 0);
      applyStimulus("rej_big", 1'b0, 1'b1, 16'd0, 16'd1473, 0);
      applyStimulus("acc_max", 1'b0, 1'b1, 16'd0, 16'd1472, 2);

      $display("[TB] timeout");
      checkOutput("timeout", 1'b0);
      checkOutput("collision", 1'b1);

      $display("[TB] reset mid-packet");
      req1_valid    = 1'b1;
      req1_byte_num = 16'd64;
      tick();
      req1_valid = 1'b0;
      checkBit("midrst_grant1", req1_grant, 1'b1);
      tick();
      req0_data = $urandom;
      req1_data = $urandom;
      tx_req    = 1'b1;
      #1;
      checkBit("midrst_rd1_before", req1_rd, 1'b1);
      rst = 1'b1;
      #1;
      checkBit("midrst_busy", busy, 1'b0);
      checkBit("midrst_rd1", req1_rd, 1'b0);
      checkWord("midrst_bytenum", {16'd0, tx_byte_num}, 32'd0);
      checkWord("midrst_txdata", tx_data, req0_data);
      tx_req = 1'b0;
      tick();
      tick();
      rst     = 1'b0;
      rrLast  = 1'b1;
      heldLen = 16'd0;
      tick();
      applyStimulus("post_both", 1'b1, 1'b1, 16'd20, 16'd30, 1);
      applyStimulus("post_ch1", 1'b0, 1'b1, 16'd0, 16'd40, 1);
      applyStimulus("post_both2", 1'b1, 1'b1, 16'd50, 16'd60, 1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 12; i++) begin
         bit a, b;
         a = ($urandom_range(0, 1) == 1);
         b = ($urandom_range(0, 1) == 1);
         if (!a && !b) a = 1'b1;
         applyStimulus("rand", a, b, randLen(), randLen(), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
